// File: rtl/top_k_ctrl.sv
// ============================================================================
// top_k_ctrl
// ----------------------------------------------------------------------------
// Sequencer for a K-deep chain of top-k compare/swap units on the rx path of
// the user kernel. One batch is handled in four phases:
//   1. A TLAST-delimited batch of integers is passed through into the head of
//      the chain.
//   2. The controller waits for the chain to drain.
//   3. The K unit registers are snapshotted and sent out as a K-beat result
//      stream, largest value first.
//   4. A clear marker (bit INTEGER_SIZE set) is injected so that the chain
//      starts empty for the next batch.
//
// The clear phase also runs straight out of reset. Any batch that was only
// partly fed in when reset hit is therefore wiped from the chain before new
// data is accepted.
//
// Parameters
//   INTEGER_SIZE : element width. A chain word is INTEGER_SIZE+1 bits wide,
//                  and its MSB is the clear marker.
//   K            : number of units in the chain (>= 1). It is also the number
//                  of result beats per batch.
//   CNT_W        : width of the element and batch counters.
//
// Ports
//   clk, rst        : clock; asynchronous active-high reset
//   s_rx_*          : batch input stream (TDATA/TVALID/TLAST in, TREADY out)
//   chain_*         : word stream into unit 0 (TDATA/TVALID/TLAST out,
//                     TREADY in)
//   chain_en        : enable to all units. It is low during reset and high
//                     from the first clock edge after reset is released.
//   unit_TDATA      : packed register values of all units. Unit i is at
//                     [i*INTEGER_SIZE +: INTEGER_SIZE], and unit 0 is the
//                     head of the chain.
//   m_res_*         : result stream (TDATA/TVALID/TLAST out, TREADY in)
//   busy            : high in every state except IDLE
//   elem_count      : elements accepted in the current or last batch. It
//                     saturates at all-ones.
//   batch_count     : number of completed batches. It wraps.
// ============================================================================
module top_k_ctrl #(
    parameter int INTEGER_SIZE = 32,
    parameter int K            = 8,
    parameter int CNT_W        = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [INTEGER_SIZE-1:0]   s_rx_TDATA,
    input  logic                      s_rx_TVALID,
    input  logic                      s_rx_TLAST,
    output logic                      s_rx_TREADY,

    output logic [INTEGER_SIZE:0]     chain_TDATA,
    output logic                      chain_TVALID,
    output logic                      chain_TLAST,
    input  logic                      chain_TREADY,
    output logic                      chain_en,

    input  logic [K*INTEGER_SIZE-1:0] unit_TDATA,

    output logic [INTEGER_SIZE-1:0]   m_res_TDATA,
    output logic                      m_res_TVALID,
    output logic                      m_res_TLAST,
    input  logic                      m_res_TREADY,

    output logic                      busy,
    output logic [CNT_W-1:0]          elem_count,
    output logic [CNT_W-1:0]          batch_count
);

    // A K=1 chain still needs a one-bit index.
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    // The drain counter must be able to hold K+1.
    localparam int DRN_W = $clog2(K + 2);

    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(K + 1);
    localparam logic [DRN_W-1:0] DRAIN_ONE  = DRN_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(K - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        CLEAR,
        CLR_WAIT,
        IDLE,
        STREAM,
        DRAIN,
        SNAP,
        EMIT
    } state_t;

    state_t                  state;
    logic [DRN_W-1:0]        drain_cnt;
    logic [IDX_W-1:0]        emit_idx;
    logic [INTEGER_SIZE-1:0] snapshot [K];

    // Sequencer. Every state change and every counter update lives here.
    //
    // chain_en doubles as a "first edge after reset seen" flag. The marker
    // beat in CLEAR is gated by it, so that all chain outputs read 0 while
    // reset is held.
    //
    // The drain counter is loaded with K+1. The wait states leave on the
    // edge where the counter steps from 1 to 0, which gives exactly K+1
    // wait cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= CLEAR;
            chain_en    <= 1'b0;
            drain_cnt   <= '0;
            emit_idx    <= '0;
            elem_count  <= '0;
            batch_count <= '0;
            for (int i = 0; i < K; i++) begin
                snapshot[i] <= '0;
            end
        end else begin
            chain_en <= 1'b1;
            case (state)
                CLEAR: begin
                    if (chain_en && chain_TREADY) begin
                        drain_cnt <= DRAIN_LOAD;
                        state     <= CLR_WAIT;
                    end
                end

                CLR_WAIT: begin
                    if (drain_cnt <= DRAIN_ONE) begin
                        drain_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_ONE;
                    end
                end

                // IDLE only detects that a batch is starting. The first
                // element is consumed in STREAM on the following cycle.
                IDLE: begin
                    if (s_rx_TVALID) begin
                        elem_count <= '0;
                        state      <= STREAM;
                    end
                end

                STREAM: begin
                    if (s_rx_TVALID && chain_TREADY) begin
                        if (elem_count != '1) begin
                            elem_count <= elem_count + CNT_ONE;
                        end
                        if (s_rx_TLAST) begin
                            drain_cnt <= DRAIN_LOAD;
                            state     <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (drain_cnt <= DRAIN_ONE) begin
                        drain_cnt <= '0;
                        state     <= SNAP;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_ONE;
                    end
                end

                SNAP: begin
                    for (int i = 0; i < K; i++) begin
                        snapshot[i] <= unit_TDATA[i*INTEGER_SIZE +: INTEGER_SIZE];
                    end
                    emit_idx <= '0;
                    state    <= EMIT;
                end

                EMIT: begin
                    if (m_res_TREADY) begin
                        if (emit_idx == LAST_IDX) begin
                            batch_count <= batch_count + CNT_ONE;
                            emit_idx    <= '0;
                            state       <= CLEAR;
                        end else begin
                            emit_idx <= emit_idx + IDX_ONE;
                        end
                    end
                end

                default: state <= CLEAR;
            endcase
        end
    end

    // Output decode. These are pure functions of registered state, except
    // for the STREAM pass-through. In STREAM, rx ready follows chain ready
    // combinationally, so an element moves into the chain with no bubble.
    //
    // The result data comes from the frozen snapshot and the index only
    // moves on a handshake, so TDATA and TLAST hold steady while
    // downstream stalls.
    always_comb begin
        s_rx_TREADY  = 1'b0;
        chain_TDATA  = '0;
        chain_TVALID = 1'b0;
        chain_TLAST  = 1'b0;
        m_res_TDATA  = '0;
        m_res_TVALID = 1'b0;
        m_res_TLAST  = 1'b0;
        busy         = (state != IDLE);

        case (state)
            CLEAR: begin
                if (chain_en) begin
                    chain_TDATA  = {1'b1, {INTEGER_SIZE{1'b0}}};
                    chain_TVALID = 1'b1;
                    chain_TLAST  = 1'b1;
                end
            end

            STREAM: begin
                s_rx_TREADY  = chain_TREADY;
                chain_TDATA  = {1'b0, s_rx_TDATA};
                chain_TVALID = s_rx_TVALID;
                chain_TLAST  = s_rx_TLAST;
            end

            EMIT: begin
                m_res_TDATA  = snapshot[emit_idx];
                m_res_TVALID = 1'b1;
                m_res_TLAST  = (emit_idx == LAST_IDX);
            end

            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_top_k_ctrl.sv
// ============================================================================
// tb_top_k_ctrl
// ----------------------------------------------------------------------------
// Bench for top_k_ctrl with K=4. It contains a small behavioural top-k chain:
//   - the marker word clears every unit;
//   - any other accepted word is inserted in descending order.
// Each batch's expected result is built independently by sorting the batch.
// The K-beat result is pushed to a scoreboard queue before the batch is
// driven, and is popped as result beats are accepted.
// ============================================================================
module tb_top_k_ctrl;

    localparam int INTEGER_SIZE = 32;
    localparam int K            = 4;
    localparam int CNT_W        = 32;

    logic                      clk;
    logic                      rst;
    logic [INTEGER_SIZE-1:0]   s_rx_TDATA;
    logic                      s_rx_TVALID;
    logic                      s_rx_TLAST;
    logic                      s_rx_TREADY;
    logic [INTEGER_SIZE:0]     chain_TDATA;
    logic                      chain_TVALID;
    logic                      chain_TLAST;
    logic                      chain_TREADY;
    logic                      chain_en;
    logic [K*INTEGER_SIZE-1:0] unit_TDATA;
    logic [INTEGER_SIZE-1:0]   m_res_TDATA;
    logic                      m_res_TVALID;
    logic                      m_res_TLAST;
    logic                      m_res_TREADY;
    logic                      busy;
    logic [CNT_W-1:0]          elem_count;
    logic [CNT_W-1:0]          batch_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] batch_q [$];
    logic [31:0] exp_q   [$];

    logic [K*INTEGER_SIZE-1:0] unit_reg = '0;

    top_k_ctrl #(
        .INTEGER_SIZE (INTEGER_SIZE),
        .K            (K),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_rx_TDATA   (s_rx_TDATA),
        .s_rx_TVALID  (s_rx_TVALID),
        .s_rx_TLAST   (s_rx_TLAST),
        .s_rx_TREADY  (s_rx_TREADY),
        .chain_TDATA  (chain_TDATA),
        .chain_TVALID (chain_TVALID),
        .chain_TLAST  (chain_TLAST),
        .chain_TREADY (chain_TREADY),
        .chain_en     (chain_en),
        .unit_TDATA   (unit_TDATA),
        .m_res_TDATA  (m_res_TDATA),
        .m_res_TVALID (m_res_TVALID),
        .m_res_TLAST  (m_res_TLAST),
        .m_res_TREADY (m_res_TREADY),
        .busy         (busy),
        .elem_count   (elem_count),
        .batch_count  (batch_count)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural chain: insert v in descending order and drop the smallest
    // value off the end.
    function automatic logic [K*INTEGER_SIZE-1:0] insert_top(
        input logic [K*INTEGER_SIZE-1:0] cur,
        input logic [INTEGER_SIZE-1:0]   v
    );
        logic [K*INTEGER_SIZE-1:0] res;
        logic [INTEGER_SIZE-1:0]   carry;
        logic [INTEGER_SIZE-1:0]   u;
        res   = cur;
        carry = v;
        for (int i = 0; i < K; i++) begin
            u = cur[i*INTEGER_SIZE +: INTEGER_SIZE];
            if (carry > u) begin
                res[i*INTEGER_SIZE +: INTEGER_SIZE] = carry;
                carry = u;
            end
        end
        return res;
    endfunction

    // The chain only reacts when enabled and on a word handshake. The marker
    // bit wipes every unit.
    always @(posedge clk) begin
        if (chain_en && chain_TVALID && chain_TREADY) begin
            if (chain_TDATA[INTEGER_SIZE]) begin
                unit_reg <= '0;
            end else begin
                unit_reg <= insert_top(unit_reg, chain_TDATA[INTEGER_SIZE-1:0]);
            end
        end
    end

    assign unit_TDATA = unit_reg;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Builds the expected K beats from batch_q: sort descending, keep the
    // top K, and pad with zeros.
    task automatic push_expected();
        logic [31:0] s [$];
        logic [31:0] t;
        s = batch_q;
        for (int i = 0; i < s.size(); i++) begin
            for (int j = 0; j + 1 < s.size() - i; j++) begin
                if (s[j] < s[j+1]) begin
                    t      = s[j];
                    s[j]   = s[j+1];
                    s[j+1] = t;
                end
            end
        end
        for (int i = 0; i < K; i++) begin
            exp_q.push_back((i < s.size()) ? s[i] : 32'd0);
        end
    endtask

    // Called just after a negedge. Holds the element until it is accepted,
    // and checks the chain pass-through on the accepting cycle.
    task automatic send_elem(input logic [31:0] d, input logic l);
        logic done;
        done        = 1'b0;
        s_rx_TDATA  = d;
        s_rx_TVALID = 1'b1;
        s_rx_TLAST  = l;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (s_rx_TREADY) begin
                done = 1'b1;
                check_output("chain_pass", {chain_TVALID, chain_TLAST, chain_TDATA},
                             {1'b1, l, 1'b0, d});
            end
            @(negedge clk);
        end
        s_rx_TVALID = 1'b0;
        s_rx_TLAST  = 1'b0;
        check_output("send_accepted", {63'd0, done}, 64'd1);
    endtask

    task automatic send_batch();
        for (int i = 0; i < batch_q.size(); i++) begin
            send_elem(batch_q[i], (i == batch_q.size() - 1));
        end
    endtask

    // Collects K result beats. With toggle set, ready is raised only on odd
    // cycles. A stalled beat must be presented unchanged on the next cycle.
    task automatic collect_results(input logic toggle);
        int          beats;
        logic        stalled;
        logic [31:0] held_data;
        logic        held_last;
        logic [31:0] exp_v;
        beats   = 0;
        stalled = 1'b0;
        for (int c = 0; c < 300 && beats < K; c++) begin
            @(negedge clk);
            m_res_TREADY = toggle ? ((c % 2) == 1) : 1'b1;
            #1;
            if (stalled) begin
                check_output("res_hold", {m_res_TVALID, m_res_TLAST, m_res_TDATA},
                             {1'b1, held_last, held_data});
            end
            stalled = 1'b0;
            if (m_res_TVALID) begin
                if (m_res_TREADY) begin
                    exp_v = exp_q.pop_front();
                    check_output("res_data", {32'd0, m_res_TDATA}, {32'd0, exp_v});
                    check_output("res_last", {63'd0, m_res_TLAST}, {63'd0, (beats == K - 1)});
                    beats++;
                end else begin
                    stalled   = 1'b1;
                    held_data = m_res_TDATA;
                    held_last = m_res_TLAST;
                end
            end
        end
        check_output("res_beats", 64'(beats), 64'(K));
        step();
        m_res_TREADY = 1'b0;
    endtask

    initial begin
        int          markers;
        int          idle_cycles;
        logic        seen_marker;
        logic        reached_idle;
        logic [31:0] ec_before;

        rst          = 1'b1;
        s_rx_TDATA   = '0;
        s_rx_TVALID  = 1'b0;
        s_rx_TLAST   = 1'b0;
        chain_TREADY = 1'b1;
        m_res_TREADY = 1'b0;

        // --- Test 1: reset values, one marker beat, K+1 wait cycles, then IDLE.
        step();
        step();
        check_output("rst_busy",      {63'd0, busy}, 64'd1);
        check_output("rst_chain_en",  {63'd0, chain_en}, 64'd0);
        check_output("rst_chain_out", {chain_TVALID, chain_TLAST, chain_TDATA}, 64'd0);
        check_output("rst_outs",      {s_rx_TREADY, m_res_TVALID, m_res_TLAST, m_res_TDATA}, 64'd0);
        check_output("rst_counts",    {elem_count, batch_count}, 64'd0);
        rst = 1'b0;

        markers      = 0;
        idle_cycles  = 0;
        seen_marker  = 1'b0;
        reached_idle = 1'b0;
        for (int c = 0; c < 50 && !reached_idle; c++) begin
            step();
            if (!busy) begin
                reached_idle = 1'b1;
            end else if (chain_TVALID && chain_TREADY) begin
                markers++;
                seen_marker = 1'b1;
                check_output("marker_word", {chain_TLAST, chain_TDATA},
                             {1'b1, 1'b1, 32'd0});
            end else if (seen_marker) begin
                idle_cycles++;
            end
        end
        check_output("clr_reached_idle", {63'd0, reached_idle}, 64'd1);
        check_output("clr_markers",      64'(markers), 64'd1);
        check_output("clr_wait_cycles",  64'(idle_cycles), 64'(K + 1));
        check_output("idle_chain_en",    {63'd0, chain_en}, 64'd1);

        // --- Test 2: five elements; the DRAIN stall is checked right after TLAST.
        $display("[TB] batch 5,9,1,7,3");
        batch_q = '{32'd5, 32'd9, 32'd1, 32'd7, 32'd3};
        push_expected();
        send_batch();
        s_rx_TDATA  = 32'd99;
        s_rx_TVALID = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_output("drain_stall_ready", {63'd0, s_rx_TREADY}, 64'd0);
            step();
        end
        s_rx_TVALID = 1'b0;
        check_output("drain_elem_hold", 64'(elem_count), 64'd5);
        collect_results(1'b0);
        check_output("b1_elem_count",  64'(elem_count), 64'd5);
        check_output("b1_batch_count", 64'(batch_count), 64'd1);

        // --- Test 3: a batch shorter than K pads the result with zeros.
        $display("[TB] batch 4,2");
        batch_q = '{32'd4, 32'd2};
        push_expected();
        send_batch();
        collect_results(1'b0);
        check_output("b2_elem_count",  64'(elem_count), 64'd2);
        check_output("b2_batch_count", 64'(batch_count), 64'd2);

        // --- Test 5: chain back-pressure in the middle of STREAM.
        $display("[TB] batch 11,13,12,14 with chain stall");
        batch_q = '{32'd11, 32'd13, 32'd12, 32'd14};
        push_expected();
        send_elem(32'd11, 1'b0);
        send_elem(32'd13, 1'b0);
        ec_before    = elem_count;
        chain_TREADY = 1'b0;
        s_rx_TDATA   = 32'd12;
        s_rx_TVALID  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_output("stall_ready", {63'd0, s_rx_TREADY}, 64'd0);
            check_output("stall_elem",  64'(elem_count), 64'd2);
            step();
        end
        check_output("stall_elem_same", 64'(elem_count), 64'(ec_before));
        chain_TREADY = 1'b1;
        send_elem(32'd12, 1'b0);
        send_elem(32'd14, 1'b1);
        collect_results(1'b0);
        check_output("b3_elem_count", 64'(elem_count), 64'd4);

        // --- Test 4: result back-pressure on alternating cycles.
        $display("[TB] batch 10,30,20 with toggling result ready");
        batch_q = '{32'd10, 32'd30, 32'd20};
        push_expected();
        send_batch();
        collect_results(1'b1);
        check_output("b4_batch_count", 64'(batch_count), 64'd4);

        // --- Test 6: reset in the middle of a batch, then a clean batch.
        $display("[TB] reset mid batch, then batch 8,6");
        send_elem(32'd50, 1'b0);
        send_elem(32'd60, 1'b0);
        rst = 1'b1;
        #1;
        check_output("abort_busy",     {63'd0, busy}, 64'd1);
        check_output("abort_chain",    {chain_en, chain_TVALID, s_rx_TREADY, m_res_TVALID}, 64'd0);
        check_output("abort_counts",   {elem_count, batch_count}, 64'd0);
        step();
        rst = 1'b0;
        batch_q = '{32'd8, 32'd6};
        push_expected();
        send_batch();
        collect_results(1'b0);
        check_output("b5_elem_count",  64'(elem_count), 64'd2);
        check_output("b5_batch_count", 64'(batch_count), 64'd1);
        check_output("sb_empty",       64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
